// File: rtl/quant_4x4.sv
// H.264 forward quantizer for one 4x4 block of transform coefficients.
// Captures a block, quantizes one coefficient per cycle, then holds the levels until the consumer takes them.
module quant_4x4 #(
   parameter int unsigned IN_BITS  = 32,
   parameter int unsigned OUT_BITS = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic signed [IN_BITS-1:0]  coeffs_i [16],
   input  logic        [5:0]          qp_i,
   input  logic                       intra_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic signed [OUT_BITS-1:0] levels_o [16],
   output logic        [4:0]          nz_count_o
);

   localparam int unsigned PROD_W = IN_BITS + 16;
   localparam int unsigned MF_W   = 14;
   localparam int unsigned F_W    = 24;
   localparam logic [PROD_W-1:0] MAG_MAX = (PROD_W'(1) << (OUT_BITS - 1)) - PROD_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

   state_e                     state_q, state_d;
   logic        [3:0]          cnt_q, cnt_d;
   logic signed [IN_BITS-1:0]  coef_q [16];
   logic signed [IN_BITS-1:0]  coef_d [16];
   logic        [3:0]          qp_div_q, qp_div_d;
   logic        [2:0]          qp_mod_q, qp_mod_d;
   logic                       intra_q, intra_d;
   logic signed [OUT_BITS-1:0] levels_q [16];
   logic signed [OUT_BITS-1:0] levels_d [16];
   logic        [4:0]          nz_q, nz_d;
   logic                       in_ready_q, in_ready_d;
   logic                       out_valid_q, out_valid_d;

   logic        [5:0]          qp_cl_c;
   logic signed [IN_BITS:0]    w_ext_c;
   logic        [IN_BITS:0]    abs_w_c;
   logic                       is_a_c, is_b_c;
   logic        [MF_W-1:0]     mf_c;
   logic        [F_W-1:0]      f_intra_c, f_c;
   logic        [4:0]          qbits_c;
   logic        [PROD_W-1:0]   sum_c, mag_c;
   logic        [OUT_BITS-1:0] mag_sat_c;
   logic signed [OUT_BITS-1:0] lvl_c;

   // Datapath for the coefficient selected by the counter.
   always_comb begin
      w_ext_c = (IN_BITS+1)'(coef_q[cnt_q]);
      abs_w_c = w_ext_c[IN_BITS] ? $unsigned(-w_ext_c) : $unsigned(w_ext_c);
      is_a_c  = ~cnt_q[0] & ~cnt_q[2];
      is_b_c  =  cnt_q[0] &  cnt_q[2];
      mf_c    = '0;
      case (qp_mod_q)
         3'd0:    mf_c = is_a_c ? 14'd13107 : (is_b_c ? 14'd5243 : 14'd8066);
         3'd1:    mf_c = is_a_c ? 14'd11916 : (is_b_c ? 14'd4660 : 14'd7490);
         3'd2:    mf_c = is_a_c ? 14'd10082 : (is_b_c ? 14'd4194 : 14'd6554);
         3'd3:    mf_c = is_a_c ? 14'd9362  : (is_b_c ? 14'd3647 : 14'd5825);
         3'd4:    mf_c = is_a_c ? 14'd8192  : (is_b_c ? 14'd3355 : 14'd5243);
         3'd5:    mf_c = is_a_c ? 14'd7282  : (is_b_c ? 14'd2893 : 14'd4559);
         default: mf_c = '0;
      endcase
      // floor(2^qbits/3); the inter offset floor(2^qbits/6) is exactly half of it, floored
      f_intra_c = '0;
      case (qp_div_q)
         4'd0:    f_intra_c = 24'd10922;
         4'd1:    f_intra_c = 24'd21845;
         4'd2:    f_intra_c = 24'd43690;
         4'd3:    f_intra_c = 24'd87381;
         4'd4:    f_intra_c = 24'd174762;
         4'd5:    f_intra_c = 24'd349525;
         4'd6:    f_intra_c = 24'd699050;
         4'd7:    f_intra_c = 24'd1398101;
         4'd8:    f_intra_c = 24'd2796202;
         default: f_intra_c = '0;
      endcase
      f_c       = intra_q ? f_intra_c : (f_intra_c >> 1);
      qbits_c   = 5'd15 + {1'b0, qp_div_q};
      sum_c     = PROD_W'(abs_w_c) * PROD_W'(mf_c) + PROD_W'(f_c);
      mag_c     = sum_c >> qbits_c;
      mag_sat_c = (mag_c > MAG_MAX) ? OUT_BITS'(MAG_MAX) : mag_c[OUT_BITS-1:0];
      lvl_c     = w_ext_c[IN_BITS] ? -$signed(mag_sat_c) : $signed(mag_sat_c);
   end

   assign qp_cl_c = (qp_i > 6'd51) ? 6'd51 : qp_i;

   // Next-state and register updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      coef_d   = coef_q;
      qp_div_d = qp_div_q;
      qp_mod_d = qp_mod_q;
      intra_d  = intra_q;
      levels_d = levels_q;
      nz_d     = nz_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i && in_ready_q) begin
               coef_d   = coeffs_i;
               qp_div_d = 4'(qp_cl_c / 6'd6);
               qp_mod_d = 3'(qp_cl_c % 6'd6);
               intra_d  = intra_i;
               nz_d     = '0;
               cnt_d    = '0;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            levels_d[cnt_q] = lvl_c;
            nz_d            = nz_q + 5'(lvl_c != '0);
            cnt_d           = cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         coef_q      <= '{default: '0};
         qp_div_q    <= '0;
         qp_mod_q    <= '0;
         intra_q     <= 1'b0;
         levels_q    <= '{default: '0};
         nz_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         coef_q      <= coef_d;
         qp_div_q    <= qp_div_d;
         qp_mod_q    <= qp_mod_d;
         intra_q     <= intra_d;
         levels_q    <= levels_d;
         nz_q        <= nz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign levels_o    = levels_q;
   assign nz_count_o  = nz_q;

endmodule

// File: tb/tb_quant_4x4.sv
// Self-checking bench for quant_4x4: directed and random blocks against an arithmetic reference model.
module tb_quant_4x4;

   logic               clk = 1'b0;
   logic               reset_ni;
   logic               in_valid_i;
   logic               in_ready_o;
   logic signed [31:0] coeffs_i [16];
   logic        [5:0]  qp_i;
   logic               intra_i;
   logic               out_valid_o;
   logic               out_ready_i;
   logic signed [15:0] levels_o [16];
   logic        [4:0]  nz_count_o;

   int checks = 0;
   int errors = 0;

   int mf_tab [6][3] = '{'{13107, 5243, 8066}, '{11916, 4660, 7490}, '{10082, 4194, 6554},
                         '{9362, 3647, 5825},  '{8192, 3355, 5243},  '{7282, 2893, 4559}};

   logic signed [31:0] blk_c [4][16];
   int                 blk_qp [4];
   bit                 blk_intra [4];

   always #5 clk = ~clk;

   quant_4x4 dut (
      .clk_i      (clk),
      .reset_ni   (reset_ni),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .coeffs_i   (coeffs_i),
      .qp_i       (qp_i),
      .intra_i    (intra_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .levels_o   (levels_o),
      .nz_count_o (nz_count_o)
   );

   // Reference: level = sign(W) * min(32767, (|W|*MF + f) >> qbits)
   function automatic int model_level(longint w, int qp, bit intra, int k);
      int     q, qb, cls;
      longint f, mf, a, mag;
      q   = (qp > 51) ? 51 : qp;
      qb  = 15 + q / 6;
      f   = (longint'(1) << qb) / (intra ? 3 : 6);
      cls = (k == 0 || k == 2 || k == 8 || k == 10) ? 0 :
            (k == 5 || k == 7 || k == 13 || k == 15) ? 1 : 2;
      mf  = longint'(mf_tab[q % 6][cls]);
      a   = (w < 0) ? -w : w;
      mag = (a * mf + f) >> qb;
      if (mag > 32767) mag = 32767;
      return int'((w < 0) ? -mag : mag);
   endfunction

   function automatic int model_nz(int b, int qp);
      int n = 0;
      for (int k = 0; k < 16; k++)
         if (model_level(longint'(blk_c[b][k]), qp, blk_intra[b], k) != 0) n++;
      return n;
   endfunction

   function automatic logic signed [31:0] rnd_coef();
      case ($urandom_range(0, 3))
         0:       return 32'sd0;
         1:       return 32'(int'($urandom_range(0, 2000)) - 1000);
         2:       return 32'(int'($urandom_range(0, 200000)) - 100000);
         default: return $urandom;
      endcase
   endfunction

   task automatic rnd_block(input int b);
      for (int k = 0; k < 16; k++) blk_c[b][k] = rnd_coef();
      blk_qp[b]    = int'($urandom_range(0, 63));
      blk_intra[b] = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_block(input int b);
      for (int k = 0; k < 16; k++) coeffs_i[k] = blk_c[b][k];
      qp_i       = 6'(blk_qp[b]);
      intra_i    = blk_intra[b];
      in_valid_i = 1'b1;
   endtask

   task automatic scramble_inputs();
      for (int k = 0; k < 16; k++) coeffs_i[k] = $urandom;
      qp_i    = 6'($urandom);
      intra_i = 1'($urandom);
   endtask

   // Called at a negedge; returns at the negedge after the acceptance edge.
   task automatic wait_accept(output bit ok);
      int n = 0;
      while (!in_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = in_ready_o;
      if (ok) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // lat counts edges with the acceptance edge as 1.
   task automatic wait_valid(output bit ok, output int lat);
      lat = 1;
      while (!out_valid_o && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      ok = out_valid_o;
   endtask

   task automatic run_block(input int b, output bit ok, output int lat);
      bit ok_a, ok_v;
      ok_v = 1'b0;
      lat  = 0;
      @(negedge clk);
      drive_block(b);
      wait_accept(ok_a);
      in_valid_i = 1'b0;
      scramble_inputs();
      if (ok_a) wait_valid(ok_v, lat);
      ok = ok_a && ok_v;
   endtask

   task automatic test_reset();
      bit ok;
      bit seen_valid;
      reset_ni    = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      scramble_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_ni = 1'b1;
      @(negedge clk);
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
      checks++; if (nz_count_o !== 5'd0) begin errors++; $display("FAIL reset_nz got %0d want 0", nz_count_o); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (levels_o[k] !== 16'sd0) begin errors++; $display("FAIL reset_level[%0d] got %0d want 0", k, levels_o[k]); end
      end
      // abort a block mid-flight
      rnd_block(0);
      drive_block(0);
      wait_accept(ok);
      in_valid_i = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL midreset_accept got timeout want accept"); end
      repeat (5) @(negedge clk);
      reset_ni = 1'b0;
      @(negedge clk);
      reset_ni = 1'b1;
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", in_ready_o); end
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", out_valid_o); end
      checks++; if (nz_count_o !== 5'd0) begin errors++; $display("FAIL midreset_nz got %0d want 0", nz_count_o); end
      seen_valid = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid_o !== 1'b0) seen_valid = 1'b1;
      end
      checks++; if (seen_valid) begin errors++; $display("FAIL midreset_no_output got out_valid pulse want none"); end
   endtask

   task automatic test_directed();
      bit ok;
      int lat;
      for (int k = 0; k < 16; k++) blk_c[0][k] = 32'sd0;
      blk_c[0][0] = 32'sd640;
      blk_c[0][1] = 32'sd200;
      blk_c[0][5] = -32'sd640;
      blk_qp[0]    = 28;
      blk_intra[0] = 1'b1;
      run_block(0, ok, lat);
      checks++; if (!ok) begin errors++; $display("FAIL directed_handshake got timeout want out_valid"); end
      checks++; if (lat != 17) begin errors++; $display("FAIL directed_latency got %0d want 17", lat); end
      checks++; if (levels_o[0] !== 16'sd10) begin errors++; $display("FAIL directed_l0 got %0d want 10", levels_o[0]); end
      checks++; if (levels_o[1] !== 16'sd2) begin errors++; $display("FAIL directed_l1 got %0d want 2", levels_o[1]); end
      checks++; if (levels_o[5] !== -16'sd4) begin errors++; $display("FAIL directed_l5 got %0d want -4", levels_o[5]); end
      checks++; if (nz_count_o !== 5'd3) begin errors++; $display("FAIL directed_nz got %0d want 3", nz_count_o); end
      for (int k = 0; k < 16; k++) begin
         int e = model_level(longint'(blk_c[0][k]), 28, 1'b1, k);
         checks++;
         if (levels_o[k] !== 16'(e)) begin errors++; $display("FAIL directed_level[%0d] got %0d want %0d", k, levels_o[k], e); end
      end
   endtask

   task automatic test_small_values();
      bit ok;
      int lat;
      int want [3] = '{0, 0, 2};
      int vals [3] = '{1, 1, 5};
      bit intr [3] = '{1'b1, 1'b0, 1'b1};
      for (int t = 0; t < 3; t++) begin
         for (int k = 0; k < 16; k++) blk_c[0][k] = 32'sd0;
         blk_c[0][0]  = 32'(vals[t]);
         blk_qp[0]    = 0;
         blk_intra[0] = intr[t];
         run_block(0, ok, lat);
         checks++; if (!ok) begin errors++; $display("FAIL small%0d_handshake got timeout want out_valid", t); end
         checks++; if (levels_o[0] !== 16'(want[t])) begin errors++; $display("FAIL small%0d_l0 got %0d want %0d", t, levels_o[0], want[t]); end
         checks++; if (nz_count_o !== 5'(want[t] != 0)) begin errors++; $display("FAIL small%0d_nz got %0d want %0d", t, nz_count_o, want[t] != 0); end
      end
   endtask

   task automatic test_saturation();
      bit ok;
      int lat;
      logic signed [31:0] extremes [2] = '{32'sh7FFF_FFFF, 32'sh8000_0000};
      logic signed [15:0] want [2] = '{16'sd32767, -16'sd32767};
      for (int t = 0; t < 2; t++) begin
         for (int k = 0; k < 16; k++) blk_c[0][k] = 32'sd0;
         blk_c[0][0]  = extremes[t];
         blk_qp[0]    = 0;
         blk_intra[0] = 1'b1;
         run_block(0, ok, lat);
         checks++; if (!ok) begin errors++; $display("FAIL sat%0d_handshake got timeout want out_valid", t); end
         checks++; if (levels_o[0] !== want[t]) begin errors++; $display("FAIL sat%0d_l0 got %0d want %0d", t, levels_o[0], want[t]); end
      end
      // qp above 51 behaves exactly as qp 51
      rnd_block(0);
      for (int k = 0; k < 16; k++) blk_c[0][k] = 32'($urandom);
      blk_qp[0] = 63;
      run_block(0, ok, lat);
      checks++; if (!ok) begin errors++; $display("FAIL qpclamp_handshake got timeout want out_valid"); end
      for (int k = 0; k < 16; k++) begin
         int e = model_level(longint'(blk_c[0][k]), 51, blk_intra[0], k);
         checks++;
         if (levels_o[k] !== 16'(e)) begin errors++; $display("FAIL qpclamp_level[%0d] got %0d want %0d", k, levels_o[k], e); end
      end
      checks++;
      if (nz_count_o !== 5'(model_nz(0, 51))) begin errors++; $display("FAIL qpclamp_nz got %0d want %0d", nz_count_o, model_nz(0, 51)); end
   endtask

   task automatic test_random();
      bit ok;
      int lat;
      for (int n = 0; n < 12; n++) begin
         rnd_block(0);
         run_block(0, ok, lat);
         checks++; if (!ok || lat != 17) begin errors++; $display("FAIL rand%0d_latency got %0d ok=%b want 17", n, lat, ok); end
         for (int k = 0; k < 16; k++) begin
            int e = model_level(longint'(blk_c[0][k]), blk_qp[0], blk_intra[0], k);
            checks++;
            if (levels_o[k] !== 16'(e)) begin
               errors++;
               $display("FAIL rand%0d_level[%0d] got %0d want %0d (w=%0d qp=%0d intra=%b)", n, k, levels_o[k], e, blk_c[0][k], blk_qp[0], blk_intra[0]);
            end
         end
         checks++;
         if (nz_count_o !== 5'(model_nz(0, blk_qp[0]))) begin errors++; $display("FAIL rand%0d_nz got %0d want %0d", n, nz_count_o, model_nz(0, blk_qp[0])); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int lat, p, bad;
      rnd_block(1);
      rnd_block(2);
      rnd_block(3);
      @(negedge clk);
      out_ready_i = 1'b0;
      drive_block(1);
      wait_accept(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_accept_a got timeout want accept"); end
      drive_block(2);
      wait_valid(ok, lat);
      checks++; if (!ok || lat != 17) begin errors++; $display("FAIL b2b_latency_a got %0d ok=%b want 17", lat, ok); end
      // backpressure: output held, queued block not taken
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         bad = 0;
         for (int k = 0; k < 16; k++)
            if (levels_o[k] !== 16'(model_level(longint'(blk_c[1][k]), blk_qp[1], blk_intra[1], k))) bad++;
         checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL hold%0d_out_valid got %b want 1", c, out_valid_o); end
         checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got %b want 0", c, in_ready_o); end
         checks++; if (bad != 0) begin errors++; $display("FAIL hold%0d_levels got %0d wrong levels want 0", c, bad); end
         checks++;
         if (nz_count_o !== 5'(model_nz(1, blk_qp[1]))) begin errors++; $display("FAIL hold%0d_nz got %0d want %0d", c, nz_count_o, model_nz(1, blk_qp[1])); end
      end
      out_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL release got in_ready=%b out_valid=%b want 1/0", in_ready_o, out_valid_o); end
      @(posedge clk);
      @(negedge clk);
      drive_block(3);
      // p counts edges after the acceptance of block B
      p = 0;
      while (!out_valid_o && p < 100) begin
         @(posedge clk);
         p++;
         @(negedge clk);
      end
      checks++; if (p != 16) begin errors++; $display("FAIL b2b_latency_b got %0d edges after accept want 16", p); end
      bad = 0;
      for (int k = 0; k < 16; k++)
         if (levels_o[k] !== 16'(model_level(longint'(blk_c[2][k]), blk_qp[2], blk_intra[2], k))) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_levels_b got %0d wrong levels want 0", bad); end
      checks++;
      if (nz_count_o !== 5'(model_nz(2, blk_qp[2]))) begin errors++; $display("FAIL b2b_nz_b got %0d want %0d", nz_count_o, model_nz(2, blk_qp[2])); end
      while (!in_ready_o && p < 100) begin
         @(posedge clk);
         p++;
         @(negedge clk);
      end
      @(posedge clk);
      p++;
      @(negedge clk);
      in_valid_i = 1'b0;
      scramble_inputs();
      checks++; if (p != 18) begin errors++; $display("FAIL b2b_period got %0d want 18", p); end
      wait_valid(ok, lat);
      checks++; if (!ok || lat != 17) begin errors++; $display("FAIL b2b_latency_c got %0d ok=%b want 17", lat, ok); end
      bad = 0;
      for (int k = 0; k < 16; k++)
         if (levels_o[k] !== 16'(model_level(longint'(blk_c[3][k]), blk_qp[3], blk_intra[3], k))) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_levels_c got %0d wrong levels want 0", bad); end
      checks++;
      if (nz_count_o !== 5'(model_nz(3, blk_qp[3]))) begin errors++; $display("FAIL b2b_nz_c got %0d want %0d", nz_count_o, model_nz(3, blk_qp[3])); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_small_values();
      test_saturation();
      test_random();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion want finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
